imem_loader: RTL

//  Boot-time writer for the instruction memory; the program-store counterpart of the

---
 rtl/imem_loader_pkg.sv | 23 ++
 rtl/loader_timeout.sv | 32 +++
 rtl/imem_loader.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and helpers for the boot-time instruction memory loader.
// Frame layout: SYNC, LEN_LO, LEN_HI, N*4 payload bytes, XOR checksum.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN_LO,
        ST_LEN_HI,
        ST_DATA,
        ST_CSUM,
        ST_DONE,
        ST_ERR
    } loader_state_e;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
    localparam int         LEN_BYTES         = 2;

    // Word index to byte address of a 32-bit word.
    function automatic logic [31:0] word_bytes_to_addr(input logic [31:0] index);
        return index << 2;
    endfunction

endpackage

// File: rtl/loader_timeout.sv
// Loadable down-counter: flags expiry after CYCLES consecutive enabled clocks
// with no reload in between.
module loader_timeout #(
    parameter int unsigned CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic reload,
    input  logic enable,
    output logic expired
);

    localparam int              CNT_W = $clog2(CYCLES + 1);
    localparam logic [CNT_W-1:0] LOAD = CNT_W'(CYCLES - 1);

    logic [CNT_W-1:0] count_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its inputs from the same pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else if (reload) begin
            count_q <= LOAD;
        end else if (enable && count_q != '0) begin
            count_q <= count_q - CNT_W'(1);
        end
    end

    assign expired = enable && (count_q == '0);

endmodule

// File: rtl/imem_loader.sv
// Boot loader: frames a UART byte stream, packs little-endian words into the
// instruction RAM write port and releases cpu_hold after a clean load.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int          ADDR_W         = 12,
    parameter int          DEPTH          = 128,
    parameter logic [7:0]  SYNC_BYTE      = SYNC_BYTE_DEFAULT,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              load_error
);

    localparam int IDX_W = $clog2(DEPTH) + 1;
    localparam int LEN_W = 8 * LEN_BYTES;

    loader_state_e    state_q, state_d;
    logic [LEN_W-1:0] len_q;
    logic [IDX_W-1:0] index_q;
    logic [1:0]       lane_q;
    logic [23:0]      shift_q;
    logic [7:0]       csum_q;

    logic frame_start, take_len_lo, take_len_hi, take_data;
    logic set_done, set_error;
    logic tmo_reload, tmo_enable, tmo_expired;
    logic in_frame, len_too_long, len_zero, last_word;
    logic [LEN_W-1:0] len_full;

    assign in_frame = (state_q == ST_LEN_LO) || (state_q == ST_LEN_HI) ||
                      (state_q == ST_DATA)   || (state_q == ST_CSUM);

    assign len_full     = {rx_data, len_q[7:0]};
    assign len_too_long = len_full > LEN_W'(DEPTH);
    assign len_zero     = len_full == '0;
    assign last_word    = (LEN_W'(index_q) + LEN_W'(1)) == len_q;

    loader_timeout #(
        .CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .reset_n (reset_n),
        .reload  (tmo_reload),
        .enable  (tmo_enable),
        .expired (tmo_expired)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        frame_start = 1'b0;
        take_len_lo = 1'b0;
        take_len_hi = 1'b0;
        take_data   = 1'b0;
        set_done    = 1'b0;
        set_error   = 1'b0;
        tmo_reload  = 1'b0;
        tmo_enable  = 1'b0;

        unique case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (rx_valid && rx_data == SYNC_BYTE) begin
                    state_d     = ST_LEN_LO;
                    frame_start = 1'b1;
                    tmo_reload  = 1'b1;
                end
            end
            ST_LEN_LO: begin
                if (rx_valid) begin
                    take_len_lo = 1'b1;
                    state_d     = ST_LEN_HI;
                end
            end
            ST_LEN_HI: begin
                if (rx_valid) begin
                    take_len_hi = 1'b1;
                    if (len_too_long) begin
                        state_d   = ST_ERR;
                        set_error = 1'b1;
                    end else if (len_zero) begin
                        state_d = ST_CSUM;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (rx_valid) begin
                    take_data = 1'b1;
                    if (lane_q == 2'd3 && last_word) begin
                        state_d = ST_CSUM;
                    end
                end
            end
            ST_CSUM: begin
                if (rx_valid) begin
                    if (rx_data == csum_q) begin
                        state_d  = ST_DONE;
                        set_done = 1'b1;
                    end else begin
                        state_d   = ST_ERR;
                        set_error = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Inside a frame every byte restarts the idle window; silence counts down.
        if (in_frame) begin
            tmo_reload = rx_valid;
            tmo_enable = !rx_valid;
            if (tmo_expired) begin
                state_d   = ST_ERR;
                set_error = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            len_q      <= '0;
            index_q    <= '0;
            lane_q     <= '0;
            shift_q    <= '0;
            csum_q     <= '0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            cpu_hold   <= 1'b1;
            load_done  <= 1'b0;
            load_error <= 1'b0;
        end else begin
            mem_we <= 1'b0;

            if (frame_start) begin
                len_q      <= '0;
                index_q    <= '0;
                lane_q     <= '0;
                csum_q     <= '0;
                load_done  <= 1'b0;
                load_error <= 1'b0;
                cpu_hold   <= 1'b1;
            end

            if (take_len_lo) len_q[7:0]  <= rx_data;
            if (take_len_hi) len_q[15:8] <= rx_data;

            // Bytes enter at the top so byte 0 of the group lands in [7:0].
            if (take_data) begin
                csum_q <= csum_q ^ rx_data;
                lane_q <= lane_q + 2'd1;
                if (lane_q == 2'd3) begin
                    mem_we    <= 1'b1;
                    mem_addr  <= ADDR_W'(word_bytes_to_addr(32'(index_q)));
                    mem_wdata <= {rx_data, shift_q};
                    index_q   <= index_q + IDX_W'(1);
                end else begin
                    shift_q <= {rx_data, shift_q[23:8]};
                end
            end

            if (set_done) begin
                load_done <= 1'b1;
                cpu_hold  <= 1'b0;
            end
            if (set_error) begin
                load_error <= 1'b1;
                cpu_hold   <= 1'b1;
            end
        end
    end

endmodule
